// File: rtl/ltcminer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ltcminer_pkg : shared types/constants for the golden-nonce UART reporter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ltcminer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'hAA;
  localparam int         NONCE_BYTES = 4;
  localparam int         FIFO_CNT_W  = 5;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_byte : 8N1 serializer, one byte per strobe, BAUD_DIV clk per bit |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_byte
  import ltcminer_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] byte_i,
  input  logic       strobe_i,
  output logic       done_o,
  output logic       tx_o
);

  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        bit_end;

  assign bit_end = (cnt_q == 16'd0);
  assign done_o  = (state_q == ST_STOP) && bit_end;
  assign tx_o    = tx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (strobe_i) begin
            shift_q <= byte_i;
            cnt_q   <= RELOAD;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt_q   <= RELOAD;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q <= RELOAD;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            // A strobe on the last stop cycle chains the next byte with no gap.
            if (strobe_i) begin
              shift_q <= byte_i;
              cnt_q   <= RELOAD;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/golden_nonce_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | golden_nonce_tx : nonce FIFO + 4-byte UART frame sequencer               |
// | Option: GOLDEN_NONCE_TX_SYNC_EN prefixes each frame with SYNC_BYTE. R1.0 |
// +--------------------------------------------------------------------------+
module golden_nonce_tx
  import ltcminer_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  hash_clk,
  input  logic                  reset_n,
  input  logic                  golden_nonce_valid,
  input  logic [31:0]           golden_nonce,
  output logic                  tx,
  output logic                  busy,
  output logic                  overflow,
  output logic [FIFO_CNT_W-1:0] fifo_count
);

  localparam int                    PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);
`ifdef GOLDEN_NONCE_TX_SYNC_EN
  localparam logic [2:0]            LAST_IDX = 3'(NONCE_BYTES);
`else
  localparam logic [2:0]            LAST_IDX = 3'(NONCE_BYTES - 1);
`endif

  logic [31:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  overflow_q;
  tx_state_e             state_q;
  logic [31:0]           shift_q;
  logic [2:0]            left_q;

  logic        full, pop, push;
  logic        ser_strobe, ser_done;
  logic [7:0]  ser_byte, first_byte;
  logic [31:0] head;

  assign head = mem_q[rd_ptr_q];
  assign full = (count_q == FULL_CNT);
  assign pop  = (state_q == ST_LOAD);
  assign push = golden_nonce_valid && (!full || pop);

`ifdef GOLDEN_NONCE_TX_SYNC_EN
  assign first_byte = SYNC_BYTE;
`else
  assign first_byte = head[7:0];
`endif

  assign ser_strobe = pop || ((state_q == ST_DATA) && ser_done && (left_q != 3'd0));
  assign ser_byte   = pop ? first_byte : shift_q[7:0];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (push) mem_q[wr_ptr_q] <= golden_nonce;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (golden_nonce_valid && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Frame sequencer; the serializer owns START/DATA/STOP, so this FSM parks
  // in ST_DATA while the frame's bytes are being shifted out.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      left_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (push || (count_q != '0)) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
`ifdef GOLDEN_NONCE_TX_SYNC_EN
          shift_q <= head;
`else
          shift_q <= {8'h00, head[31:8]};
`endif
          left_q  <= LAST_IDX;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (ser_done) begin
            if (left_q == 3'd0) begin
              state_q <= ST_IDLE;
            end else begin
              shift_q <= {8'h00, shift_q[31:8]};
              left_q  <= left_q - 3'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk_i    (hash_clk),
    .rst_ni   (reset_n),
    .byte_i   (ser_byte),
    .strobe_i (ser_strobe),
    .done_o   (ser_done),
    .tx_o     (tx)
  );

  assign busy       = (count_q != '0) || (state_q != ST_IDLE);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_golden_nonce_tx : directed bench, BAUD_DIV=4 FIFO_DEPTH=4             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_golden_nonce_tx;

  localparam int BD = 4;
`ifdef GOLDEN_NONCE_TX_SYNC_EN
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif
  localparam int LOAD2_K = 3 + 10 * BD * FB;

  logic        hash_clk;
  logic        reset_n;
  logic        golden_nonce_valid;
  logic [31:0] golden_nonce;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [4:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] vals [6] = '{32'h11223344, 32'hA5A50F0F, 32'h00FF00FF,
                            32'hFFFFFFFF, 32'h80000001, 32'hCAFEBABE};
  logic [31:0] bq   [5] = '{32'h01020304, 32'h55AA55AA, 32'h76543210,
                            32'h0BADF00D, 32'hFEDCBA98};

  golden_nonce_tx #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (4)
  ) dut (
    .hash_clk           (hash_clk),
    .reset_n            (reset_n),
    .golden_nonce_valid (golden_nonce_valid),
    .golden_nonce       (golden_nonce),
    .tx                 (tx),
    .busy               (busy),
    .overflow           (overflow),
    .fifo_count         (fifo_count)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] frame_of(input logic [31:0] n);
`ifdef GOLDEN_NONCE_TX_SYNC_EN
    return {n, 8'hAA};
`else
    return {8'h00, n};
`endif
  endfunction

  // Finds the start bit (current sample counts), then samples every cycle:
  // every bit must hold BD identical samples, start low, stop high.
  task automatic rx_frame(input string tag, input logic [39:0] exp);
    int         waited = 0;
    int         bad;
    logic       s0;
    logic [7:0] b;
    while (tx !== 1'b0 && waited < 2000) begin
      @(negedge hash_clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check({tag, "_timeout"}, 40'(tx), 40'd0);
      return;
    end
    for (int by = 0; by < FB; by++) begin
      bad = 0;
      b   = '0;
      s0  = 1'b0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int s = 0; s < BD; s++) begin
          if (by != 0 || bi != 0 || s != 0) @(negedge hash_clk);
          if (s == 0) s0 = tx;
          else if (tx !== s0) bad++;
        end
        if (bi == 0 && s0 !== 1'b0) bad++;
        if (bi == 9 && s0 !== 1'b1) bad++;
        if (bi >= 1 && bi <= 8) b[bi-1] = s0;
      end
      check($sformatf("%s_byte%0d", tag, by), 40'(b), 40'(exp[8*by +: 8]));
      check($sformatf("%s_bits%0d", tag, by), 40'(bad), 40'd0);
    end
  endtask

  task automatic gap_check(input string tag);
    int g = 0;
    @(negedge hash_clk);
    while (tx !== 1'b0 && g < 2000) begin
      g++;
      @(negedge hash_clk);
    end
    check(tag, 40'(g), 40'd2);
  endtask

  task automatic do_reset();
    @(negedge hash_clk);
    reset_n            = 1'b0;
    golden_nonce_valid = 1'b0;
    repeat (2) @(negedge hash_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int lows;
    int hi_busy;
    reset_n            = 1'b0;
    golden_nonce_valid = 1'b0;
    golden_nonce       = '0;
    repeat (3) @(negedge hash_clk);
    check("rst_tx",   40'(tx),         40'd1);
    check("rst_busy", 40'(busy),       40'd0);
    check("rst_ovf",  40'(overflow),   40'd0);
    check("rst_cnt",  40'(fifo_count), 40'd0);

    // Single nonce, pushed on the first edge after reset release
    reset_n            = 1'b1;
    golden_nonce_valid = 1'b1;
    golden_nonce       = 32'h12345678;
    @(negedge hash_clk);
    golden_nonce_valid = 1'b0;
    check("load_tx",   40'(tx),         40'd1);
    check("load_cnt",  40'(fifo_count), 40'd1);
    check("load_busy", 40'(busy),       40'd1);
    @(negedge hash_clk);
    check("lat_tx",  40'(tx),         40'd0);
    check("lat_cnt", 40'(fifo_count), 40'd0);
    rx_frame("single", frame_of(32'h12345678));
    check("stop_busy", 40'(busy), 40'd1);
    @(negedge hash_clk);
    check("idle_busy", 40'(busy), 40'd0);
    check("idle_tx",   40'(tx),   40'd1);

    // Six back-to-back pushes: five fit (one popped early), sixth dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge hash_clk);
          golden_nonce_valid = 1'b1;
          golden_nonce       = vals[i];
        end
        @(negedge hash_clk);
        golden_nonce_valid = 1'b0;
        check("burst_ovf", 40'(overflow),   40'd1);
        check("burst_cnt", 40'(fifo_count), 40'd4);
      end
      begin
        for (int i = 0; i < 5; i++) rx_frame($sformatf("burst%0d", i), frame_of(vals[i]));
      end
    join
    @(negedge hash_clk);
    check("ovf_sticky", 40'(overflow), 40'd1);
    check("burst_idle", 40'(busy),     40'd0);
    lows = 0;
    repeat (60) begin
      @(negedge hash_clk);
      if (tx === 1'b0) lows++;
    end
    check("sixth_dropped", 40'(lows), 40'd0);

    // Push at full coinciding with the LOAD pop, then back-to-back frames
    do_reset();
    check("ovf_clr", 40'(overflow), 40'd0);
    for (int k = 0; k <= LOAD2_K + 1; k++) begin
      if (k > 0) @(negedge hash_clk);
      golden_nonce_valid = 1'b0;
      if (k == 0) begin
        golden_nonce_valid = 1'b1;
        golden_nonce       = 32'h0000_0000;
      end else if (k >= 3 && k <= 6) begin
        golden_nonce_valid = 1'b1;
        golden_nonce       = bq[k-3];
      end else if (k == LOAD2_K) begin
        check("full_pre", 40'(fifo_count), 40'd4);
        golden_nonce_valid = 1'b1;
        golden_nonce       = bq[4];
      end else if (k == LOAD2_K + 1) begin
        check("full_pushpop_cnt", 40'(fifo_count), 40'd4);
        check("full_pushpop_ovf", 40'(overflow),   40'd0);
        check("full_next_start",  40'(tx),         40'd0);
      end
    end
    rx_frame("q0", frame_of(bq[0]));
    for (int i = 1; i < 5; i++) begin
      gap_check($sformatf("gap%0d", i));
      rx_frame($sformatf("q%0d", i), frame_of(bq[i]));
    end
    @(negedge hash_clk);
    check("q_idle", 40'(busy), 40'd0);

    // Asynchronous reset during the second byte's data bits
    do_reset();
    for (int k = 0; k <= 50; k++) begin
      if (k > 0) @(negedge hash_clk);
      golden_nonce_valid = (k <= 1);
      golden_nonce       = (k == 0) ? 32'h0000_0000 : 32'h12345678;
    end
    check("pre_rst_tx",  40'(tx),         40'd0);
    check("pre_rst_cnt", 40'(fifo_count), 40'd1);
    reset_n = 1'b0;
    #1;
    check("async_tx",   40'(tx),         40'd1);
    check("async_cnt",  40'(fifo_count), 40'd0);
    check("async_busy", 40'(busy),       40'd0);
    @(negedge hash_clk);
    reset_n = 1'b1;
    lows    = 0;
    hi_busy = 0;
    repeat (200) begin
      @(negedge hash_clk);
      if (tx === 1'b0) lows++;
      if (busy === 1'b1) hi_busy++;
    end
    check("post_rst_tx",   40'(lows),    40'd0);
    check("post_rst_busy", 40'(hi_busy), 40'd0);

    do_reset();
    golden_nonce_valid = 1'b1;
    golden_nonce       = 32'hDEADBEEF;
    @(negedge hash_clk);
    golden_nonce_valid = 1'b0;
    rx_frame("deadbeef", frame_of(32'hDEADBEEF));
    check("deadbeef_ovf", 40'(overflow), 40'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
